// File: rtl/pdp11_bus_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pdp11_bus_pkg : shared types and constants for the PDP-11 bus sequencer (rev 1.0)
// ----------------------------------------------------------------------------
package pdp11_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } bus_state_e;

  typedef logic [1:0] err_cause_t;

  localparam err_cause_t  ERR_ODD     = 2'b01;
  localparam err_cause_t  ERR_TMO     = 2'b10;
  localparam logic [15:0] BUS_ERR_VEC = 16'o000004;

  // Byte reads return the addressed lane right-justified; the ALU sign-extends.
  function automatic logic [15:0] fmt_rdata(input logic [15:0] d,
                                            input logic        byte_acc,
                                            input logic        odd);
    if (!byte_acc) return d;
    return odd ? {8'h00, d[15:8]} : {8'h00, d[7:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_bus_ctrl_if : datapath request and slave bus signal bundle (rev 1.0)
// ----------------------------------------------------------------------------
interface mem_bus_ctrl_if;
  import pdp11_bus_pkg::*;

  // Datapath side (byte_acc carries the "byte" request bit; byte is a keyword)
  logic        req;
  logic        we;
  logic        byte_acc;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        done;
  logic        bus_err;
  err_cause_t  err_cause;
  logic [15:0] err_addr;

  // Slave side
  logic        m_sel;
  logic        m_we;
  logic        m_bytew;
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata;
  logic        m_ack;

  modport master (
    input  req, we, byte_acc, addr, wdata, m_rdata, m_ack,
    output rdata, done, bus_err, err_cause, err_addr,
           m_sel, m_we, m_bytew, m_addr, m_wdata
  );

  modport slave (
    output req, we, byte_acc, addr, wdata, m_rdata, m_ack,
    input  rdata, done, bus_err, err_cause, err_addr,
           m_sel, m_we, m_bytew, m_addr, m_wdata
  );

endinterface
`default_nettype wire

// File: rtl/bus_timeout_ctr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bus_timeout_ctr : wait-state counter flagging expiry at TIMEOUT-1 (rev 1.0)
// ----------------------------------------------------------------------------
module bus_timeout_ctr #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == LIMIT);

endmodule
`default_nettype wire

// File: rtl/mem_bus_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_bus_ctrl : PDP-11 memory bus sequencer with odd-address/timeout traps (rev 1.0)
// ----------------------------------------------------------------------------
module mem_bus_ctrl
  import pdp11_bus_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  mem_bus_ctrl_if.master bus
);

  bus_state_e  state_q;
  logic [15:0] addr_q;
  logic        byte_q;

  logic [15:0] rdata_q;
  logic        done_q;
  logic        bus_err_q;
  err_cause_t  err_cause_q;
  logic [15:0] err_addr_q;
  logic        m_sel_q;
  logic        m_we_q;
  logic        m_bytew_q;
  logic [15:0] m_addr_q;
  logic [15:0] m_wdata_q;

  logic        tmo_clr;
  logic        tmo_en;
  logic        tmo_expired;

  assign tmo_clr = (state_q != ST_BUS);
  assign tmo_en  = (state_q == ST_BUS) && !bus.m_ack;

  bus_timeout_ctr #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_tmo (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr_i     (tmo_clr),
    .en_i      (tmo_en),
    .expired_o (tmo_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      byte_q      <= 1'b0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      bus_err_q   <= 1'b0;
      err_cause_q <= '0;
      err_addr_q  <= '0;
      m_sel_q     <= 1'b0;
      m_we_q      <= 1'b0;
      m_bytew_q   <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
    end else begin
      done_q    <= 1'b0;
      bus_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.req) begin
            addr_q <= bus.addr;
            byte_q <= bus.byte_acc;
            // Odd word addresses trap before any slave sees the cycle.
            if (!bus.byte_acc && bus.addr[0]) begin
              state_q     <= ST_ERR;
              bus_err_q   <= 1'b1;
              err_cause_q <= ERR_ODD;
              err_addr_q  <= bus.addr;
            end else begin
              state_q   <= ST_BUS;
              m_sel_q   <= 1'b1;
              m_we_q    <= bus.we;
              m_bytew_q <= bus.byte_acc;
              m_addr_q  <= bus.addr;
              m_wdata_q <= bus.byte_acc ? {bus.wdata[7:0], bus.wdata[7:0]} : bus.wdata;
            end
          end
        end
        ST_BUS: begin
          // Ack takes priority over an expiry landing in the same cycle.
          if (bus.m_ack || tmo_expired) begin
            m_sel_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_bytew_q <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
          end
          if (bus.m_ack) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            rdata_q <= fmt_rdata(bus.m_rdata, byte_q, addr_q[0]);
          end else if (tmo_expired) begin
            state_q     <= ST_ERR;
            bus_err_q   <= 1'b1;
            err_cause_q <= ERR_TMO;
            err_addr_q  <= addr_q;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        ST_ERR:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.rdata     = rdata_q;
  assign bus.done      = done_q;
  assign bus.bus_err   = bus_err_q;
  assign bus.err_cause = err_cause_q;
  assign bus.err_addr  = err_addr_q;
  assign bus.m_sel     = m_sel_q;
  assign bus.m_we      = m_we_q;
  assign bus.m_bytew   = m_bytew_q;
  assign bus.m_addr    = m_addr_q;
  assign bus.m_wdata   = m_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_bus_ctrl : transaction-level model and per-cycle compare for mem_bus_ctrl (rev 1.0)
// ----------------------------------------------------------------------------
module tb_mem_bus_ctrl;

  localparam int TIMEOUT = 16;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  mem_bus_ctrl_if bus ();

  mem_bus_ctrl #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Expected outputs for the current cycle, set just after each rising edge
  logic        exp_sel = 1'b0, exp_done = 1'b0, exp_err = 1'b0;
  logic        exp_we = 1'b0, exp_bytew = 1'b0;
  logic [15:0] exp_addr = '0, exp_wdata = '0, exp_rdata = '0, exp_err_addr = '0;
  logic [1:0]  exp_cause = '0;

  // Per-transaction observations used by the directed literal checks
  int          model_term;
  int          obs_sel_cnt;
  logic        obs_done, obs_err, obs_m_we, obs_m_bytew;
  logic [15:0] obs_rdata, obs_err_addr, obs_m_addr, obs_m_wdata;
  logic [1:0]  obs_cause;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s t=%0t: actual %h required %h", name, $time, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_sel",     16'(bus.m_sel),     16'(exp_sel));
      chk("done",      16'(bus.done),      16'(exp_done));
      chk("bus_err",   16'(bus.bus_err),   16'(exp_err));
      chk("rdata",     bus.rdata,          exp_rdata);
      chk("err_cause", 16'(bus.err_cause), 16'(exp_cause));
      chk("err_addr",  bus.err_addr,       exp_err_addr);
      if (exp_sel) begin
        chk("m_addr",  bus.m_addr,         exp_addr);
        chk("m_we",    16'(bus.m_we),      16'(exp_we));
        chk("m_bytew", 16'(bus.m_bytew),   16'(exp_bytew));
        chk("m_wdata", bus.m_wdata,        exp_wdata);
      end
    end
  end

  task automatic next_phase();
    @(posedge clk);
    #1;
  endtask

  task automatic junk_fields();
    bus.addr     = 16'($urandom);
    bus.we       = 1'($urandom);
    bus.byte_acc = 1'($urandom);
    bus.wdata    = 16'($urandom);
  endtask

  task automatic junk_slave();
    bus.m_ack   = 1'($urandom_range(0, 1));
    bus.m_rdata = 16'($urandom);
  endtask

  task automatic exp_quiet();
    exp_sel  = 1'b0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      next_phase();
      bus.req = 1'b0;
      junk_fields();
      junk_slave();
      exp_quiet();
    end
  endtask

  // One access: the slave acks in bus cycle number `waits` (0 = first cycle).
  task automatic run_txn(input logic [15:0] a, input logic w_e, input logic b,
                         input logic [15:0] wd, input int waits, input logic [15:0] rd,
                         input bit keep_req);
    bit odd, ok;
    int lastbus, term;
    odd     = !b && a[0];
    ok      = (waits <= TIMEOUT - 1);
    lastbus = ok ? waits : TIMEOUT - 1;
    term    = odd ? 0 : lastbus + 1;
    model_term  = term;
    obs_sel_cnt = 0;

    next_phase();
    bus.req = 1'b1; bus.addr = a; bus.we = w_e; bus.byte_acc = b; bus.wdata = wd;
    exp_quiet();
    junk_slave();

    for (int p = 0; p <= term; p++) begin
      next_phase();
      junk_fields();
      bus.req   = (p == term) ? keep_req : 1'b1;
      exp_sel   = !odd && (p <= lastbus);
      exp_addr  = a;
      exp_we    = w_e;
      exp_bytew = b;
      exp_wdata = b ? {wd[7:0], wd[7:0]} : wd;
      exp_done  = !odd && ok && (p == term);
      exp_err   = (p == term) && !exp_done;
      if (exp_done)
        exp_rdata = !b ? rd : (a[0] ? {8'h00, rd[15:8]} : {8'h00, rd[7:0]});
      if (exp_err) begin
        exp_cause    = odd ? 2'b01 : 2'b10;
        exp_err_addr = a;
      end
      if (exp_sel) begin
        bus.m_ack   = (p == waits);
        bus.m_rdata = (p == waits) ? rd : 16'($urandom);
      end else begin
        junk_slave();
      end
      obs_sel_cnt += int'(bus.m_sel);
      if (p == 0) begin
        obs_m_addr  = bus.m_addr;
        obs_m_we    = bus.m_we;
        obs_m_bytew = bus.m_bytew;
        obs_m_wdata = bus.m_wdata;
      end
      if (p == term) begin
        obs_done     = bus.done;
        obs_err      = bus.bus_err;
        obs_rdata    = bus.rdata;
        obs_cause    = bus.err_cause;
        obs_err_addr = bus.err_addr;
      end
    end
  endtask

  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.byte_acc = 1'b0; bus.addr = '0; bus.wdata = '0;
    bus.m_ack = 1'b0; bus.m_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_m_sel", 16'(bus.m_sel), 16'd0);
    chk("rst_rdata", bus.rdata, 16'd0);
    chk("rst_cause", 16'(bus.err_cause), 16'd0);
    reset_n = 1'b1;

    // Zero-wait word read
    run_txn(16'o001000, 1'b0, 1'b0, 16'h0000, 0, 16'o012737, 1'b0);
    chk("rd1_lat_model", 16'(model_term), 16'd1);
    chk("rd1_done", 16'(obs_done), 16'd1);
    chk("rd1_err", 16'(obs_err), 16'd0);
    chk("rd1_rdata", obs_rdata, 16'o012737);

    // Byte write to odd address replicates the low byte
    run_txn(16'o001001, 1'b1, 1'b1, 16'h00A5, 0, 16'h0000, 1'b0);
    chk("bw_bytew", 16'(obs_m_bytew), 16'd1);
    chk("bw_wdata", obs_m_wdata, 16'hA5A5);
    chk("bw_addr", obs_m_addr, 16'o001001);
    chk("bw_we", 16'(obs_m_we), 16'd1);
    chk("bw_selcnt", 16'(obs_sel_cnt), 16'd1);
    chk("bw_done", 16'(obs_done), 16'd1);

    // Odd word read traps without a bus cycle
    run_txn(16'o001003, 1'b0, 1'b0, 16'h0000, 0, 16'hFFFF, 1'b0);
    chk("odd_selcnt", 16'(obs_sel_cnt), 16'd0);
    chk("odd_err", 16'(obs_err), 16'd1);
    chk("odd_cause", 16'(obs_cause), 16'b01);
    chk("odd_eaddr", obs_err_addr, 16'o001003);

    // Byte read of the high lane with three wait states
    run_txn(16'o000777, 1'b0, 1'b1, 16'h0000, 3, 16'h8F12, 1'b0);
    chk("br_lat_model", 16'(model_term), 16'd4);
    chk("br_done", 16'(obs_done), 16'd1);
    chk("br_rdata", obs_rdata, 16'h008F);

    // Non-responding slave, then a back-to-back recovery write
    run_txn(16'o004000, 1'b0, 1'b0, 16'h0000, 1000, 16'h0000, 1'b0);
    chk("tmo_selcnt", 16'(obs_sel_cnt), 16'd16);
    chk("tmo_err", 16'(obs_err), 16'd1);
    chk("tmo_cause", 16'(obs_cause), 16'b10);
    chk("tmo_eaddr", obs_err_addr, 16'o004000);
    run_txn(16'o004002, 1'b1, 1'b0, 16'hBEEF, 2, 16'h1357, 1'b1);
    chk("after_tmo_done", 16'(obs_done), 16'd1);

    // Ack in the last allowed cycle completes normally
    run_txn(16'o006000, 1'b0, 1'b0, 16'h0000, TIMEOUT - 1, 16'h2468, 1'b0);
    chk("edge_done", 16'(obs_done), 16'd1);
    chk("edge_selcnt", 16'(obs_sel_cnt), 16'd16);
    chk("edge_rdata", obs_rdata, 16'h2468);

    // Asynchronous reset in the second bus cycle
    next_phase();
    bus.req = 1'b1; bus.addr = 16'o002000; bus.we = 1'b0; bus.byte_acc = 1'b0; bus.wdata = 16'h1234;
    bus.m_ack = 1'b0;
    exp_quiet();
    for (int p = 0; p < 2; p++) begin
      next_phase();
      junk_fields();
      bus.m_ack = 1'b0;
      exp_sel = 1'b1; exp_addr = 16'o002000; exp_we = 1'b0; exp_bytew = 1'b0; exp_wdata = 16'h1234;
    end
    #1;
    reset_n = 1'b0;
    bus.req = 1'b0;
    exp_quiet();
    exp_rdata = '0; exp_cause = '0; exp_err_addr = '0;
    #1;
    chk("arst_m_sel", 16'(bus.m_sel), 16'd0);
    chk("arst_done", 16'(bus.done), 16'd0);
    chk("arst_err", 16'(bus.bus_err), 16'd0);
    next_phase();
    next_phase();
    reset_n = 1'b1;
    run_txn(16'o002000, 1'b0, 1'b0, 16'h0000, 1, 16'o055555, 1'b0);
    chk("post_rst_done", 16'(obs_done), 16'd1);
    chk("post_rst_rdata", obs_rdata, 16'o055555);

    // Randomized traffic
    for (int t = 0; t < 200; t++) begin
      int r, w;
      bit kr;
      r = int'($urandom_range(0, 9));
      if (r < 7)       w = int'($urandom_range(0, 4));
      else if (r == 7) w = TIMEOUT - 1;
      else if (r == 8) w = TIMEOUT;
      else             w = TIMEOUT + int'($urandom_range(1, 5));
      kr = 1'($urandom);
      run_txn(16'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), w, 16'($urandom), kr);
      if (!kr) idle(int'($urandom_range(0, 2)));
    end

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
